// File: rtl/serial_sum_collector_pkg.sv
// Shared definitions for the serial sum collector: FSM encodings and frame sizing.
// Frame length grows by one carry bit when SUM_CARRY_EN is defined.
package serial_sum_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

`ifdef SUM_CARRY_EN
    localparam int CARRY_BITS = 1;
`else
    localparam int CARRY_BITS = 0;
`endif

    function automatic int frame_len(input int reglength);
        return reglength + CARRY_BITS;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_sum_collector_sipo_shreg.sv
// Serial-in parallel-out shift register; new bits enter at the MSB end and move toward bit 0.
// q_shifted exposes the value q would take on an enabled edge.
module sipo_shreg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q,
    output logic [W-1:0] q_shifted
);

    logic [W-1:0] q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (gi == W - 1) begin : g_top
                assign q_shifted[gi] = din;
            end else begin : g_mid
                assign q_shifted[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= q_shifted;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the LSB-first serial sum into a parallel word with a valid/ready handshake.
// Define SUM_CARRY_EN to capture the summator carry-out as an extra MSB.
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int reglength = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              sum_bit,
    input  logic                              ready,
    output logic [frame_len(reglength)-1:0]   result,
    output logic                              valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int N  = frame_len(reglength);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam bit SINGLE_BIT = (N == 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  result_reg, result_next;
    logic          overrun_reg, overrun_next;
    logic          shift_en;
    logic          begin_frame;
    logic [N-1:0]  sreg_q;
    logic [N-1:0]  sreg_shifted;

    sipo_shreg #(.W(N)) u_shreg (
        .clk       (clk),
        .clr       (rst),
        .en        (shift_en),
        .din       (sum_bit),
        .q         (sreg_q),
        .q_shifted (sreg_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            result_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        overrun_next = overrun_reg;
        shift_en     = 1'b0;
        begin_frame  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                begin_frame = start;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (start) begin
                    overrun_next = 1'b1;
                end
                if (cnt_reg == LAST_CNT) begin
                    result_next = sreg_shifted;
                    state_next  = ST_HOLD;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_HOLD: begin
                // A start coinciding with ready hands off the word and opens the next frame.
                if (ready) begin
                    state_next  = ST_IDLE;
                    begin_frame = start;
                end else if (start) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (begin_frame) begin
            shift_en = 1'b1;
            if (SINGLE_BIT) begin
                result_next = sreg_shifted;
                state_next  = ST_HOLD;
                cnt_next    = '0;
            end else begin
                state_next = ST_SHIFT;
                cnt_next   = CW'(1);
            end
        end
    end

    assign result  = result_reg;
    assign valid   = (state_reg == ST_HOLD);
    assign busy    = (state_reg == ST_SHIFT);
    assign overrun = overrun_reg;

    logic unused_sreg;
    assign unused_sreg = ^sreg_q;

endmodule

// File: tb/tb_serial_sum_collector.sv
// Bench for serial_sum_collector: directed scenarios plus randomized traffic against a word-level model.
module tb_serial_sum_collector;

    localparam int RL = 3;
`ifdef SUM_CARRY_EN
    localparam int N = RL + 1;
`else
    localparam int N = RL;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sum_bit = 1'b0;
    logic         ready = 1'b0;
    logic [N-1:0] result;
    logic         valid;
    logic         busy;
    logic         overrun;

    serial_sum_collector #(.reglength(RL)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sum_bit (sum_bit),
        .ready   (ready),
        .result  (result),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Word-level reference: a frame is a list of N bits, the word is their weighted sum.
    bit m_collecting;
    int m_nbits;
    int m_acc;
    bit m_have;
    int m_held;
    bit m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_begin(input bit b);
        m_acc   = int'(b);
        m_nbits = 1;
        if (N == 1) begin
            m_have = 1'b1;
            m_held = m_acc;
        end else begin
            m_collecting = 1'b1;
        end
    endtask

    task automatic model_clock(input bit s, input bit b, input bit r, input bit rs);
        if (rs) begin
            m_collecting = 1'b0; m_nbits = 0; m_acc = 0;
            m_have = 1'b0; m_held = 0; m_ovr = 1'b0;
        end else if (m_collecting) begin
            if (s) m_ovr = 1'b1;
            m_acc = m_acc + (int'(b) << m_nbits);
            m_nbits++;
            if (m_nbits == N) begin
                m_collecting = 1'b0;
                m_have = 1'b1;
                m_held = m_acc;
            end
        end else if (m_have) begin
            if (r) begin
                m_have = 1'b0;
                if (s) model_begin(b);
            end else if (s) begin
                m_ovr = 1'b1;
            end
        end else if (s) begin
            model_begin(b);
        end
    endtask

    // One clock: drive, clock, update model, check all outputs, print one line.
    task automatic step(input string tag, input bit s, input bit b, input bit r, input bit rs);
        logic [N-1:0] exp_res;
        start = s; sum_bit = b; ready = r; rst = rs;
        @(posedge clk);
        model_clock(s, b, r, rs);
        #1;
        exp_res = m_held[N-1:0];
        $display("%s: rst=%0b start=%0b bit=%0b ready=%0b -> result=%0h valid=%0b busy=%0b overrun=%0b",
                 tag, rs, s, b, r, result, valid, busy, overrun);
        chk({tag, ".result"},  32'(result),  32'(exp_res));
        chk({tag, ".valid"},   32'(valid),   32'(m_have));
        chk({tag, ".busy"},    32'(busy),    32'(m_collecting));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send_frame(input string tag, input int word, input bit r);
        for (int k = 0; k < N; k++) begin
            step(tag, k == 0, bit'((word >> k) & 1), r, 1'b0);
        end
    endtask

    initial begin
        logic [N-1:0] exp_w;
        m_collecting = 0; m_nbits = 0; m_acc = 0; m_have = 0; m_held = 0; m_ovr = 0;

        step("init_rst", 0, 0, 0, 1);
        step("init_rst", 0, 0, 0, 1);

        // Reset in the middle of a frame discards it.
        step("t1_pre", 1, 1, 0, 0);
        step("t1_pre", 0, 1, 0, 0);
        step("t1_rst", 0, 0, 0, 1);
        step("t1_rst", 0, 0, 0, 1);
        chk("t1_valid_zero", 32'(valid), 32'd0);

        // Frame 1,0,1 with ready high: valid after the last bit, gone one cycle later.
        send_frame("t2", 5, 1'b1);
        exp_w = N'(5);
        chk("t2_result_101", 32'(result), 32'(exp_w));
        chk("t2_valid_up", 32'(valid), 32'd1);
        step("t2_drop", 0, 0, 1, 0);
        chk("t2_valid_down", 32'(valid), 32'd0);

        // Held result survives a dropped start; overrun latches.
        send_frame("t3", 5, 1'b0);
        step("t3_start_hold", 1, 1, 0, 0);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_result_kept", 32'(result), 32'(exp_w));
        step("t3_accept", 0, 0, 1, 0);

        // Back-to-back frames with start coinciding with the handoff.
        step("t4_rst", 0, 0, 0, 1);
        send_frame("t4_a", 3, 1'b1);
        exp_w = N'(3);
        chk("t4_first", 32'(result), 32'(exp_w));
        send_frame("t4_b", 6, 1'b1);
        exp_w = N'(6);
        chk("t4_second", 32'(result), 32'(exp_w));
        chk("t4_valid", 32'(valid), 32'd1);
        step("t4_idle", 0, 0, 1, 0);

        // Start during SHIFT is ignored but flagged.
        step("t5_rst", 0, 0, 0, 1);
        for (int k = 0; k < N; k++) begin
            step("t5", (k == 0) || (k == 1), bit'((6 >> k) & 1), 1'b0, 1'b0);
        end
        exp_w = N'(6);
        chk("t5_result", 32'(result), 32'(exp_w));
        chk("t5_overrun", 32'(overrun), 32'd1);

        // 7+1 on the serial link: bits 0,0,0,1.
        step("t6_rst", 0, 0, 0, 1);
        step("t6", 1, 0, 0, 0);
        step("t6", 0, 0, 0, 0);
        step("t6", 0, 0, 0, 0);
        step("t6", 0, 1, 0, 0);
`ifdef SUM_CARRY_EN
        chk("t6_carry", 32'(result), 32'h8);
`else
        chk("t6_trunc", 32'(result), 32'h0);
`endif
        step("t6_accept", 0, 0, 1, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step("rnd", $urandom_range(0, 3) == 0, bit'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
